mig_seq_eval: RTL and testbench

//  Programmable, sequential majority-inverter-graph (MIG) evaluator.

---
 rtl/mig_seq_eval.sv | 171 +++++++++++++++++
 tb/tb_mig_seq_eval.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_seq_eval.sv
// mig_seq_eval: runtime-programmable majority-inverter-graph evaluator, one node per clock.
// Define MIG_TT_EN to add the tt_mode/out_tt truth-table sweep.
module mig_seq_eval #(
  parameter  int NIN   = 4,
  parameter  int NODES = 6,
  localparam int SELW  = $clog2(NIN + NODES + 1),
  localparam int CW    = SELW + 1,
  localparam int AW    = $clog2(NODES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [3*CW-1:0]   cfg_wdata,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIN-1:0]    in_x,
`ifdef MIG_TT_EN
  input  logic              tt_mode,
  output logic [2**NIN-1:0] out_tt,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y,
  output logic              busy
);

  localparam int KW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NODES - 1);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t           state, state_next;
  logic [3*CW-1:0]  node_cfg [NODES];
  logic [CW-1:0]    out_cfg;
  logic [NIN-1:0]   x_lat;
  logic [NODES-1:0] node_val, node_next;
  logic [KW-1:0]    k;
  logic [3*CW-1:0]  cur_cfg;
  logic [NIN-1:0]   eval_x;
  logic             maj_val, out_done, cfg_ok, last_step;
`ifdef MIG_TT_EN
  logic             tt_run;
  logic [NIN-1:0]   m;
  logic             tt_bit;
`endif

  // Operand decode: 0 = const, 1..NIN = inputs, then nodes; out-of-range selects read 0.
  function automatic logic op_val(input logic [CW-1:0] f, input logic [NIN-1:0] x,
                                  input logic [NODES-1:0] n);
    logic [SELW-1:0] sel;
    logic v;
    sel = f[SELW-1:0];
    v = 1'b0;
    for (int i = 0; i < NIN; i++)
      if (sel == SELW'(i + 1)) v = x[i];
    for (int i = 0; i < NODES; i++)
      if (sel == SELW'(NIN + 1 + i)) v = n[i];
    return v ^ f[CW-1];
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
`ifdef MIG_TT_EN
    eval_x = tt_run ? m : x_lat;
`else
    eval_x = x_lat;
`endif
    cur_cfg = node_cfg[k];
    maj_val = maj3(op_val(cur_cfg[0 +: CW], eval_x, node_val),
                   op_val(cur_cfg[CW +: CW], eval_x, node_val),
                   op_val(cur_cfg[2*CW +: CW], eval_x, node_val));
    node_next = node_val;
    for (int i = 0; i < NODES; i++)
      if (k == KW'(i)) node_next[i] = maj_val;
    out_done = op_val(out_cfg, x_lat, node_val);
`ifdef MIG_TT_EN
    tt_bit = op_val(out_cfg, m, node_next);
    last_step = (k == K_LAST) && (!tt_run || (m == '1));
`else
    last_step = (k == K_LAST);
`endif
    cfg_ok = cfg_we && (state == IDLE) && (cfg_addr <= AW'(NODES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EVAL;
      EVAL:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    out_y     = 1'b0;
    if (state == DONE) begin
`ifdef MIG_TT_EN
      out_y = tt_run ? out_tt[x_lat] : out_done;
`else
      out_y = out_done;
`endif
    end
  end

  // Config writes land on the same edge as an accept, so evaluation sees the new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) node_cfg[i] <= '0;
      out_cfg  <= '0;
      cfg_err  <= 1'b0;
      x_lat    <= '0;
      node_val <= '0;
      k        <= '0;
`ifdef MIG_TT_EN
      tt_run   <= 1'b0;
      m        <= '0;
      out_tt   <= '0;
`endif
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        if (cfg_addr == AW'(NODES)) out_cfg <= cfg_wdata[CW-1:0];
        else                        node_cfg[cfg_addr] <= cfg_wdata;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_lat    <= in_x;
            node_val <= '0;
            k        <= '0;
`ifdef MIG_TT_EN
            tt_run   <= tt_mode;
            m        <= '0;
`endif
          end
        end
        EVAL: begin
          node_val <= node_next;
          k        <= k + KW'(1);
          if (k == K_LAST) begin
            k <= '0;
`ifdef MIG_TT_EN
            // Sweep: record this minterm's result and restart the netlist for the next one.
            if (tt_run) begin
              out_tt[m] <= tt_bit;
              node_val  <= '0;
              m         <= m + NIN'(1);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_seq_eval.sv
// tb_mig_seq_eval: directed vector table plus hand-written handshake, config-error and reset sequences.
module tb_mig_seq_eval;

  localparam int NIN   = 4;
  localparam int NODES = 6;
  localparam int CW    = 5;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [3*CW-1:0] cfg_wdata;
  logic            cfg_err;
  logic            in_valid;
  logic            in_ready;
  logic [NIN-1:0]  in_x;
  logic            out_valid;
  logic            out_ready;
  logic            out_y;
  logic            busy;
`ifdef MIG_TT_EN
  logic            tt_mode;
  logic [15:0]     out_tt;
`endif

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [CW-1:0]  out_cfg;
    logic [NIN-1:0] x;
    logic           y;
  } vec_t;

  vec_t vecs [18];

  mig_seq_eval #(.NIN(NIN), .NODES(NODES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
`ifdef MIG_TT_EN
    .tt_mode   (tt_mode),
    .out_tt    (out_tt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeCfg(input logic [AW-1:0] addr, input logic [3*CW-1:0] data, input logic exp_err);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
    checkOutput($sformatf("cfg_err_addr%0d", addr), cfg_err, exp_err);
  endtask

  // Present one vector, then count negedges after the accept edge until out_valid.
  task automatic applyStimulus(input logic [NIN-1:0] x, output int cycles);
    in_x = x;
    in_valid = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we = 1'b0;
      cycles++;
    end while (!out_valid && cycles < 300);
  endtask

  task automatic finishResult(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, "_in_ready_after"}, in_ready, 1);
    checkOutput({name, "_out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;

    // {out_cfg, in_x, expected y}; nodes: n0=x0&x1, n1=x2|x3, n2=n0&n1, n3=MAJ(n4 fwd,1,x0), n4=1
    vecs[0]  = '{5'b00101, 4'b0011, 1'b1};
    vecs[1]  = '{5'b00101, 4'b0001, 1'b0};
    vecs[2]  = '{5'b00101, 4'b1111, 1'b1};
    vecs[3]  = '{5'b10101, 4'b0011, 1'b0};
    vecs[4]  = '{5'b10101, 4'b0000, 1'b1};
    vecs[5]  = '{5'b00110, 4'b0100, 1'b1};
    vecs[6]  = '{5'b00110, 4'b0011, 1'b0};
    vecs[7]  = '{5'b00111, 4'b0111, 1'b1};
    vecs[8]  = '{5'b00111, 4'b1101, 1'b0};
    vecs[9]  = '{5'b10000, 4'b0000, 1'b1};
    vecs[10] = '{5'b00001, 4'b1001, 1'b1};
    vecs[11] = '{5'b00100, 4'b1000, 1'b1};
    vecs[12] = '{5'b01011, 4'b1111, 1'b0};
    vecs[13] = '{5'b11111, 4'b0000, 1'b1};
    vecs[14] = '{5'b11010, 4'b0000, 1'b1};
    vecs[15] = '{5'b01000, 4'b0000, 1'b0};
    vecs[16] = '{5'b01000, 4'b0001, 1'b1};
    vecs[17] = '{5'b01001, 4'b0000, 1'b1};

    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b0;
`ifdef MIG_TT_EN
    tt_mode = 1'b0;
`endif
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_y", out_y, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cfg_err", cfg_err, 0);
`ifdef MIG_TT_EN
    checkOutput("reset_out_tt", out_tt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    writeCfg(3'd0, {5'd0, 5'd2, 5'd1}, 1'b0);
    writeCfg(3'd1, {5'b10000, 5'd4, 5'd3}, 1'b0);
    writeCfg(3'd2, {5'd0, 5'd6, 5'd5}, 1'b0);
    writeCfg(3'd3, {5'd1, 5'b10000, 5'd9}, 1'b0);
    writeCfg(3'd4, {5'b10000, 5'b10000, 5'b10000}, 1'b0);

    for (int i = 0; i < 18; i++) begin
      writeCfg(3'd6, {10'd0, vecs[i].out_cfg}, 1'b0);
      applyStimulus(vecs[i].x, cyc);
      checkOutput($sformatf("vec%0d_latency", i), cyc, NODES + 1);
      checkOutput($sformatf("vec%0d_y", i), out_y, vecs[i].y);
      finishResult($sformatf("vec%0d", i));
    end

    // Write and accept in the same cycle: evaluation must see the complemented output entry.
    writeCfg(3'd6, {10'd0, 5'b00101}, 1'b0);
    cfg_we = 1'b1;
    cfg_addr = 3'd6;
    cfg_wdata = {10'd0, 5'b10101};
    applyStimulus(4'b0011, cyc);
    checkOutput("same_cycle_y", out_y, 0);
    finishResult("same_cycle");

    // Stall the consumer: result must hold and no new vector may be taken.
    writeCfg(3'd6, {10'd0, 5'b00101}, 1'b0);
    applyStimulus(4'b0011, cyc);
    checkOutput("hold_latency", cyc, NODES + 1);
    in_x = 4'b0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d_out_valid", i), out_valid, 1);
      checkOutput($sformatf("hold%0d_out_y", i), out_y, 1);
      checkOutput($sformatf("hold%0d_in_ready", i), in_ready, 0);
    end
    in_valid = 1'b0;
    finishResult("hold");

    // Config write while evaluating is rejected and does not disturb the result.
    in_x = 4'b0011;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("eval_busy", busy, 1);
    checkOutput("eval_in_ready", in_ready, 0);
    cfg_we = 1'b1;
    cfg_addr = 3'd6;
    cfg_wdata = {10'd0, 5'b10101};
    @(negedge clk);
    cfg_we = 1'b0;
    checkOutput("busy_write_cfg_err", cfg_err, 1);
    @(negedge clk);
    checkOutput("busy_write_cfg_err_pulse_end", cfg_err, 0);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("busy_write_out_valid", out_valid, 1);
    checkOutput("busy_write_y", out_y, 1);
    finishResult("busy_write");

    writeCfg(3'd7, {10'd0, 5'b10101}, 1'b1);
    @(negedge clk);
    checkOutput("bad_addr_cfg_err_pulse_end", cfg_err, 0);
    applyStimulus(4'b0011, cyc);
    checkOutput("bad_addr_y", out_y, 1);
    finishResult("bad_addr");

    // Reset in the middle of evaluation (node 3 in progress) wipes state and config.
    in_x = 4'b1111;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4'b1111, cyc);
    checkOutput("post_reset_latency", cyc, NODES + 1);
    checkOutput("post_reset_y", out_y, 0);
    finishResult("post_reset");

`ifdef MIG_TT_EN
    writeCfg(3'd0, {5'd3, 5'd2, 5'd1}, 1'b0);
    writeCfg(3'd6, {10'd0, 5'b00101}, 1'b0);
    tt_mode = 1'b1;
    applyStimulus(4'b0011, cyc);
    tt_mode = 1'b0;
    checkOutput("tt_latency", cyc, 16 * NODES + 1);
    checkOutput("tt_table", out_tt, 32'h0000E8E8);
    checkOutput("tt_y", out_y, 1);
    finishResult("tt");
    applyStimulus(4'b0100, cyc);
    checkOutput("tt_base_y", out_y, 0);
    checkOutput("tt_base_table_hold", out_tt, 32'h0000E8E8);
    finishResult("tt_base");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
